// File: rtl/dbb_rd_arb_pkg.sv
// Shared types and helpers for the DBB 2:1 read-channel arbiter.
// AR payload packing, MSB to LSB: {addr, len, size, burst, id}.
package dbb_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  // Widest master-side ID the tagging helper can handle.
  localparam int ID_MAX_W = 64;

  function automatic int ar_pld_w(input int addr_w, input int len_w, input int size_w,
                                  input int burst_w, input int id_w);
    return addr_w + len_w + size_w + burst_w + id_w;
  endfunction

  // Field LSB offsets inside the packed AR payload (id sits at bit 0).
  function automatic int ar_burst_lsb(input int id_w);
    return id_w;
  endfunction

  function automatic int ar_size_lsb(input int id_w, input int burst_w);
    return id_w + burst_w;
  endfunction

  function automatic int ar_len_lsb(input int id_w, input int burst_w, input int size_w);
    return id_w + burst_w + size_w;
  endfunction

  function automatic int ar_addr_lsb(input int id_w, input int burst_w, input int size_w,
                                     input int len_w);
    return id_w + burst_w + size_w + len_w;
  endfunction

  // Places the source tag directly above an id_w-bit ID; bits of id above
  // id_w must be zero.
  function automatic logic [ID_MAX_W:0] widen_id(input logic src,
                                                 input logic [ID_MAX_W-1:0] id,
                                                 input int id_w);
    logic [ID_MAX_W:0] tag;
    tag = {{ID_MAX_W{1'b0}}, src} << id_w;
    return {1'b0, id} | tag;
  endfunction

endpackage

// File: rtl/dbb_rd_arb_cnt.sv
// Per-master outstanding-burst counter: +1 on AR accept, -1 on final R beat,
// simultaneous events cancel, saturates at 0 and flags a sticky underflow.
module dbb_rd_arb_cnt
  import dbb_rd_arb_pkg::*;
#(
  parameter int MAX_CNT = 8,
  localparam int CNT_W = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  // Count update and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      underflow <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (cnt != CNT_W'(MAX_CNT)) cnt <= cnt + CNT_W'(1);
        end
        2'b01: begin
          if (cnt == '0) underflow <= 1'b1;
          else           cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dbb_rd_arb.sv
// 2:1 DBB read-channel arbiter: round-robin AR grant with a source tag in
// the ID MSB, combinational R routing by that tag, and per-master
// outstanding-burst throttling. Reset drops in-flight bursts, so the slave
// has to be reset together with this block.
module dbb_rd_arb
  import dbb_rd_arb_pkg::*;
#(
  parameter int DBB_ADDR_WIDTH      = 64,
  parameter int DBB_DATA_WIDTH      = 512,
  parameter int DBB_ALEN_WIDTH      = 4,
  parameter int DBB_ASIZE_WIDTH     = 3,
  parameter int DBB_ABURST_WIDTH    = 2,
  parameter int DBB_AID_WIDTH       = 8,
  parameter int DBB_MAX_OUTSTANDING = 8,
  localparam int AR_PLD_W = ar_pld_w(DBB_ADDR_WIDTH, DBB_ALEN_WIDTH, DBB_ASIZE_WIDTH,
                                     DBB_ABURST_WIDTH, DBB_AID_WIDTH),
  localparam int CNT_W    = $clog2(DBB_MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  // master 0 AR
  input  logic                      m0_arvalid,
  output logic                      m0_arready,
  input  logic [AR_PLD_W-1:0]       m0_ar_pld,
  // master 1 AR
  input  logic                      m1_arvalid,
  output logic                      m1_arready,
  input  logic [AR_PLD_W-1:0]       m1_ar_pld,
  // master 0 R
  output logic                      m0_rvalid,
  input  logic                      m0_rready,
  output logic [DBB_DATA_WIDTH-1:0] m0_rdata,
  output logic [DBB_AID_WIDTH-1:0]  m0_rid,
  output logic                      m0_rlast,
  // master 1 R
  output logic                      m1_rvalid,
  input  logic                      m1_rready,
  output logic [DBB_DATA_WIDTH-1:0] m1_rdata,
  output logic [DBB_AID_WIDTH-1:0]  m1_rid,
  output logic                      m1_rlast,
  // slave AR
  output logic                      s_arvalid,
  input  logic                      s_arready,
  output logic [AR_PLD_W:0]         s_ar_pld,
  // slave R
  input  logic                      s_rvalid,
  output logic                      s_rready,
  input  logic [DBB_DATA_WIDTH-1:0] s_rdata,
  input  logic [DBB_AID_WIDTH:0]    s_rid,
  input  logic                      s_rlast,
  // status
  output logic [CNT_W-1:0]          m0_outstanding,
  output logic [CNT_W-1:0]          m1_outstanding,
  output logic                      err_underflow
);

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;

  logic elig0, elig1;
  logic ar_hs0, ar_hs1;
  logic r_sel, r_hs;
  logic r_done0, r_done1;
  logic uf0, uf1;

  logic [ID_MAX_W-1:0] m0_id_ext, m1_id_ext;
  logic [ID_MAX_W:0]   m0_id_tag, m1_id_tag;
  logic [AR_PLD_W:0]   s_pld_m0, s_pld_m1;
  logic                unused_id_hi;

  // Tagged slave-side payloads for each master; only the ID field changes.
  assign m0_id_ext = ID_MAX_W'(m0_ar_pld[DBB_AID_WIDTH-1:0]);
  assign m1_id_ext = ID_MAX_W'(m1_ar_pld[DBB_AID_WIDTH-1:0]);
  assign m0_id_tag = widen_id(1'b0, m0_id_ext, DBB_AID_WIDTH);
  assign m1_id_tag = widen_id(1'b1, m1_id_ext, DBB_AID_WIDTH);
  assign s_pld_m0  = {m0_ar_pld[AR_PLD_W-1:DBB_AID_WIDTH], m0_id_tag[DBB_AID_WIDTH:0]};
  assign s_pld_m1  = {m1_ar_pld[AR_PLD_W-1:DBB_AID_WIDTH], m1_id_tag[DBB_AID_WIDTH:0]};
  assign unused_id_hi = ^{m0_id_tag[ID_MAX_W:DBB_AID_WIDTH+1],
                          m1_id_tag[ID_MAX_W:DBB_AID_WIDTH+1]};

  // A master competes only while it has room for another burst in flight.
  assign elig0 = m0_arvalid && (m0_outstanding < CNT_W'(DBB_MAX_OUTSTANDING));
  assign elig1 = m1_arvalid && (m1_outstanding < CNT_W'(DBB_MAX_OUTSTANDING));

  assign ar_hs0 = (state_q == ST_GNT0) && m0_arvalid && s_arready;
  assign ar_hs1 = (state_q == ST_GNT1) && m1_arvalid && s_arready;

  // Arbiter state and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Grant selection and AR channel steering; a grant is held until the
  // slave accepts, then the other master becomes favoured.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    s_arvalid  = 1'b0;
    s_ar_pld   = s_pld_m0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (elig0 && elig1) state_d = rr_q ? ST_GNT1 : ST_GNT0;
        else if (elig0)     state_d = ST_GNT0;
        else if (elig1)     state_d = ST_GNT1;
      end
      ST_GNT0: begin
        s_arvalid  = m0_arvalid;
        s_ar_pld   = s_pld_m0;
        m0_arready = s_arready;
        if (m0_arvalid && s_arready) begin
          state_d = ST_IDLE;
          rr_d    = 1'b1;
        end
      end
      ST_GNT1: begin
        s_arvalid  = m1_arvalid;
        s_ar_pld   = s_pld_m1;
        m1_arready = s_arready;
        if (m1_arvalid && s_arready) begin
          state_d = ST_IDLE;
          rr_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // R return path: the tag bit alone selects the owner, no added latency.
  assign r_sel     = s_rid[DBB_AID_WIDTH];
  assign m0_rvalid = s_rvalid && !r_sel;
  assign m1_rvalid = s_rvalid &&  r_sel;
  assign s_rready  = r_sel ? m1_rready : m0_rready;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rid    = s_rid[DBB_AID_WIDTH-1:0];
  assign m1_rid    = s_rid[DBB_AID_WIDTH-1:0];
  assign m0_rlast  = s_rlast;
  assign m1_rlast  = s_rlast;

  assign r_hs    = s_rvalid && s_rready;
  assign r_done0 = r_hs && s_rlast && !r_sel;
  assign r_done1 = r_hs && s_rlast &&  r_sel;

  dbb_rd_arb_cnt #(.MAX_CNT(DBB_MAX_OUTSTANDING)) u_cnt0 (
    .clk       (clk),
    .rst       (rst),
    .inc       (ar_hs0),
    .dec       (r_done0),
    .cnt       (m0_outstanding),
    .underflow (uf0)
  );

  dbb_rd_arb_cnt #(.MAX_CNT(DBB_MAX_OUTSTANDING)) u_cnt1 (
    .clk       (clk),
    .rst       (rst),
    .inc       (ar_hs1),
    .dec       (r_done1),
    .cnt       (m1_outstanding),
    .underflow (uf1)
  );

  assign err_underflow = uf0 || uf1;

endmodule

// File: tb/tb_dbb_rd_arb.sv
// Scoreboard bench for dbb_rd_arb: stimulus pushes hand-computed AR
// payloads and R beats, a negedge monitor pops and compares on handshakes.
module tb_dbb_rd_arb;
  localparam int AW = 32, DW = 64, LW = 4, SW = 3, BW = 2, IW = 8, MAXO = 8;
  localparam int PW = AW + LW + SW + BW + IW;
  localparam int CW = $clog2(MAXO + 1);

  logic clk = 1'b0, rst;
  logic m0_arvalid, m0_arready, m1_arvalid, m1_arready;
  logic [PW-1:0] m0_ar_pld, m1_ar_pld;
  logic m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [IW-1:0] m0_rid, m1_rid;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [PW:0] s_ar_pld;
  logic [IW:0] s_rid;
  logic [CW-1:0] m0_outstanding, m1_outstanding;
  logic err_underflow;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } rbeat_t;

  logic [PW:0] exp_ar_q[$];
  rbeat_t      exp_r0_q[$];
  rbeat_t      exp_r1_q[$];
  int n_total = 0, n_pass = 0, cyc = 0;

  dbb_rd_arb #(
    .DBB_ADDR_WIDTH(AW), .DBB_DATA_WIDTH(DW), .DBB_ALEN_WIDTH(LW),
    .DBB_ASIZE_WIDTH(SW), .DBB_ABURST_WIDTH(BW), .DBB_AID_WIDTH(IW),
    .DBB_MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar_pld(m0_ar_pld),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar_pld(m1_ar_pld),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rid(m0_rid), .m0_rlast(m0_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .m1_rid(m1_rid), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar_pld(s_ar_pld),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .m0_outstanding(m0_outstanding), .m1_outstanding(m1_outstanding),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_chk(input string name);
    n_total++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  function automatic logic [PW-1:0] mk_pld(input logic [AW-1:0] a, input logic [IW-1:0] id);
    return {a, 4'd3, 3'd6, 2'b01, id};
  endfunction

  function automatic logic [PW:0] mk_spld(input logic src, input logic [AW-1:0] a,
                                          input logic [IW-1:0] id);
    return {a, 4'd3, 3'd6, 2'b01, src, id};
  endfunction

  // Monitor: compare whatever handshake is about to complete at the next posedge.
  always @(negedge clk) begin
    rbeat_t e;
    if (!rst) begin
      if (s_arvalid && s_arready) begin
        if (exp_ar_q.size() == 0) fail_chk("ar_unexpected");
        else chk("ar_pld", s_ar_pld, exp_ar_q.pop_front());
      end
      if (m0_rvalid && m0_rready) begin
        if (exp_r0_q.size() == 0) fail_chk("r0_unexpected");
        else begin
          e = exp_r0_q.pop_front();
          chk("r0_data", m0_rdata, e.data);
          chk("r0_id_last", {m0_rid, m0_rlast}, {e.id, e.last});
        end
      end
      if (m1_rvalid && m1_rready) begin
        if (exp_r1_q.size() == 0) fail_chk("r1_unexpected");
        else begin
          e = exp_r1_q.pop_front();
          chk("r1_data", m1_rdata, e.data);
          chk("r1_id_last", {m1_rid, m1_rlast}, {e.id, e.last});
        end
      end
    end
  end

  // Present one AR request and wait (bounded) for its acceptance.
  task automatic send_ar(input int m, input logic [AW-1:0] a, input logic [IW-1:0] id,
                         input bit keep);
    int n = 0;
    if (m == 0) begin m0_ar_pld = mk_pld(a, id); m0_arvalid = 1'b1; end
    else        begin m1_ar_pld = mk_pld(a, id); m1_arvalid = 1'b1; end
    @(negedge clk);
    while (!((m == 0) ? m0_arready : m1_arready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ar_timeout", 64'(m), 64'hFF);
    @(posedge clk); #1;
    if (!keep) begin
      if (m == 0) m0_arvalid = 1'b0;
      else        m1_arvalid = 1'b0;
    end
  endtask

  // Present one R beat from the slave and wait (bounded) for acceptance.
  task automatic send_r(input logic [IW:0] rid, input logic [DW-1:0] d, input logic last);
    int n = 0;
    s_rvalid = 1'b1; s_rid = rid; s_rdata = d; s_rlast = last;
    @(negedge clk);
    while (!s_rready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("r_timeout", 64'(rid), 64'hFFF);
    @(posedge clk); #1;
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  task automatic do_reset();
    chk("ar_q_drained", 64'(exp_ar_q.size()), 64'd0);
    chk("r_q_drained", 64'(exp_r0_q.size() + exp_r1_q.size()), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int t0;
    rst = 1'b1;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_ar_pld = '0; m1_ar_pld = '0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rid = '0; s_rlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_arready", {m0_arready, m1_arready}, 0);
    chk("rst_cnt", {m0_outstanding, m1_outstanding}, 0);
    chk("rst_err", err_underflow, 0);
    rst = 1'b0;

    // m0 alone, id 0x5A: tagged id 0x05A, valid on the second cycle.
    exp_ar_q.push_back(mk_spld(1'b0, 32'h1000, 8'h5A));
    fork
      send_ar(0, 32'h1000, 8'h5A, 1'b0);
      begin
        @(negedge clk); chk("t1_cyc1_arvalid", s_arvalid, 0);
        @(negedge clk); chk("t1_cyc2_arvalid", s_arvalid, 1);
      end
    join
    chk("t1_m0_cnt", m0_outstanding, 1);

    // Both requesting back-to-back; m1 favoured after m0's grant.
    exp_ar_q.push_back(mk_spld(1'b1, 32'h2000, 8'h11));
    exp_ar_q.push_back(mk_spld(1'b0, 32'h1100, 8'h21));
    exp_ar_q.push_back(mk_spld(1'b1, 32'h2100, 8'h12));
    exp_ar_q.push_back(mk_spld(1'b0, 32'h1200, 8'h22));
    t0 = cyc;
    fork
      begin send_ar(0, 32'h1100, 8'h21, 1'b1); send_ar(0, 32'h1200, 8'h22, 1'b0); end
      begin send_ar(1, 32'h2000, 8'h11, 1'b1); send_ar(1, 32'h2100, 8'h12, 1'b0); end
    join
    chk("t2_cycles_4_grants", 64'(cyc - t0), 64'd8);
    chk("t2_cnts", {m0_outstanding, m1_outstanding}, {4'd3, 4'd2});

    // After reset m0 is favoured first, then fill m0 to the limit.
    do_reset();
    exp_ar_q.push_back(mk_spld(1'b0, 32'h3000, 8'h30));
    exp_ar_q.push_back(mk_spld(1'b1, 32'h4000, 8'h40));
    fork
      send_ar(0, 32'h3000, 8'h30, 1'b0);
      send_ar(1, 32'h4000, 8'h40, 1'b0);
    join
    for (int i = 1; i < 8; i++) begin
      exp_ar_q.push_back(mk_spld(1'b0, 32'h3000 + 32'(i * 64), 8'(8'h30 + i)));
      send_ar(0, 32'h3000 + 32'(i * 64), 8'(8'h30 + i), 1'b0);
    end
    chk("t3_m0_full", m0_outstanding, 8);
    m0_ar_pld = mk_pld(32'h3800, 8'h3F);
    m0_arvalid = 1'b1;
    exp_ar_q.push_back(mk_spld(1'b1, 32'h4040, 8'h41));
    send_ar(1, 32'h4040, 8'h41, 1'b0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m0_arready) seen++;
    end
    chk("t3_m0_blocked", 64'(seen), 64'd0);
    @(posedge clk); #1;
    chk("t3_m0_still_full", m0_outstanding, 8);
    exp_r0_q.push_back('{data: 64'hA0, id: 8'h30, last: 1'b1});
    send_r({1'b0, 8'h30}, 64'hA0, 1'b1);
    exp_ar_q.push_back(mk_spld(1'b0, 32'h3800, 8'h3F));
    send_ar(0, 32'h3800, 8'h3F, 1'b0);
    chk("t3_cnts", {m0_outstanding, m1_outstanding}, {4'd8, 4'd2});

    // R beat for m1 held by m1_rready=0 for three cycles.
    exp_r1_q.push_back('{data: 64'hB1B1_0000_1234_5678, id: 8'hA3, last: 1'b1});
    m1_rready = 1'b0;
    s_rvalid = 1'b1; s_rid = 9'h1A3; s_rdata = 64'hB1B1_0000_1234_5678; s_rlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_m1v_m0v_srdy", {m1_rvalid, m0_rvalid, s_rready}, 3'b100);
    end
    chk("t4_cnt_during_hold", m1_outstanding, 2);
    @(posedge clk); #1;
    m1_rready = 1'b1;
    @(posedge clk); #1;
    s_rvalid = 1'b0; s_rlast = 1'b0;
    chk("t4_m1_cnt", m1_outstanding, 1);

    // AR accept and final R beat for m0 in the same cycle at count 3.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_ar_q.push_back(mk_spld(1'b0, 32'h5000 + 32'(i * 64), 8'(8'h50 + i)));
      send_ar(0, 32'h5000 + 32'(i * 64), 8'(8'h50 + i), 1'b0);
    end
    chk("t5_cnt_before", m0_outstanding, 3);
    exp_ar_q.push_back(mk_spld(1'b0, 32'h5300, 8'h53));
    exp_r0_q.push_back('{data: 64'hC0, id: 8'h50, last: 1'b1});
    fork
      send_ar(0, 32'h5300, 8'h53, 1'b0);
      begin @(posedge clk); #1; send_r({1'b0, 8'h50}, 64'hC0, 1'b1); end
    join
    chk("t5_cnt_after", m0_outstanding, 3);

    // Final beat for m1 with nothing outstanding.
    exp_r1_q.push_back('{data: 64'hD0, id: 8'h77, last: 1'b1});
    send_r({1'b1, 8'h77}, 64'hD0, 1'b1);
    chk("t6_err_underflow", err_underflow, 1);
    chk("t6_m1_cnt_sat", m1_outstanding, 0);
    chk("t6_m0_cnt_kept", m0_outstanding, 3);

    // Grant held while the slave stalls, then asynchronous reset mid-grant.
    s_arready = 1'b0;
    m0_ar_pld = mk_pld(32'h6000, 8'h60);
    m0_arvalid = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_grant_held", {s_arvalid, m0_arready, m1_arready}, 3'b100);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_s_arvalid", s_arvalid, 0);
    chk("t6_async_cnts", {m0_outstanding, m1_outstanding}, 0);
    chk("t6_async_err", err_underflow, 0);
    m0_arvalid = 1'b0;
    s_arready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("end_ar_q_drained", 64'(exp_ar_q.size()), 64'd0);
    chk("end_r_q_drained", 64'(exp_r0_q.size() + exp_r1_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
